// File: rtl/nonce_result_collector.sv
// Collects "nonce found" pulses from parallel cores into per-channel slots,
// arbitrates them round-robin into a small FIFO and presents one result at a time.
module nonce_result_collector #(
  parameter int unsigned NONCE_W       = 32,
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned COUNT_W       = 16,
  parameter int unsigned STOP_ON_FIRST = 0,
  localparam int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [CHANNELS-1:0]           ch_valid,
  input  logic [CHANNELS*NONCE_W-1:0]   ch_nonce,
  output logic                          valid_sal,
  input  logic                          ready_in,
  output logic [NONCE_W-1:0]            nonce_out,
  output logic [CH_W-1:0]               chan_out,
  output logic                          finished,
  output logic [COUNT_W-1:0]            found_count,
  output logic                          overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [CHANNELS-1:0] pend;
  logic [NONCE_W-1:0]  slot [CHANNELS];
  logic [CH_W-1:0]     rr;
  logic                stopped;

  logic [NONCE_W-1:0]  mem_nonce [DEPTH];
  logic [CH_W-1:0]     mem_chan  [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [OCC_W-1:0]    occ;

  logic                push_c;
  logic                pop_c;
  logic                freeze_c;
  logic                capture_en_c;
  logic [CH_W-1:0]     gnt_idx_c;
  logic [CHANNELS-1:0] gnt_c;
  logic [CHANNELS-1:0] load_c;
  logic [CHANNELS-1:0] drop_c;

  logic [PTR_W-1:0]    rd_next_c;
  logic [OCC_W-1:0]    occ_left_c;
  logic [OCC_W-1:0]    occ_next_c;
  logic                head_valid_c;
  logic [NONCE_W-1:0]  head_nonce_c;
  logic [CH_W-1:0]     head_chan_c;

  // Round-robin search starting just after the last granted channel
  always_comb begin
    int sum;
    push_c    = 1'b0;
    gnt_idx_c = '0;
    sum       = 0;
    if (occ != OCC_W'(DEPTH) && !stopped) begin
      for (int k = 1; k <= int'(CHANNELS); k++) begin
        sum = int'(rr) + k;
        if (sum >= int'(CHANNELS)) sum = sum - int'(CHANNELS);
        if (!push_c && pend[CH_W'(sum)]) begin
          push_c    = 1'b1;
          gnt_idx_c = CH_W'(sum);
        end
      end
    end
  end

  assign freeze_c     = push_c && (STOP_ON_FIRST != 0);
  assign capture_en_c = !stopped && !freeze_c && !clear;
  assign pop_c        = valid_sal && ready_in;

  // Slot capture: a granted slot may be refilled in the same cycle
  always_comb begin
    gnt_c  = '0;
    load_c = '0;
    drop_c = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      gnt_c[i]  = push_c && (gnt_idx_c == CH_W'(i));
      load_c[i] = ch_valid[i] && capture_en_c && (!pend[i] || gnt_c[i]);
      drop_c[i] = ch_valid[i] && capture_en_c && pend[i] && !gnt_c[i];
    end
  end

  // Next FIFO head, so the output port can be a register
  always_comb begin
    rd_next_c    = rd_ptr + PTR_W'(pop_c);
    occ_left_c   = occ - OCC_W'(pop_c);
    occ_next_c   = occ_left_c + OCC_W'(push_c);
    head_valid_c = (occ_next_c != '0);
    head_nonce_c = '0;
    head_chan_c  = '0;
    if (occ_left_c == '0 && push_c) begin
      head_nonce_c = slot[gnt_idx_c];
      head_chan_c  = gnt_idx_c;
    end else if (occ_left_c != '0) begin
      head_nonce_c = mem_nonce[rd_next_c];
      head_chan_c  = mem_chan[rd_next_c];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend        <= '0;
      overflow    <= 1'b0;
      rr          <= CH_W'(CHANNELS - 1);
      stopped     <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      finished    <= 1'b0;
      found_count <= '0;
      valid_sal   <= 1'b0;
      nonce_out   <= '0;
      chan_out    <= '0;
    end else if (clear) begin
      pend        <= '0;
      overflow    <= 1'b0;
      rr          <= CH_W'(CHANNELS - 1);
      stopped     <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      finished    <= 1'b0;
      found_count <= '0;
      valid_sal   <= 1'b0;
      nonce_out   <= '0;
      chan_out    <= '0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (freeze_c)       pend[i] <= 1'b0;
        else if (load_c[i]) pend[i] <= 1'b1;
        else if (gnt_c[i])  pend[i] <= 1'b0;
      end
      if (|drop_c) overflow <= 1'b1;
      if (push_c) begin
        rr       <= gnt_idx_c;
        wr_ptr   <= wr_ptr + PTR_W'(1);
        finished <= 1'b1;
        if (found_count != '1) found_count <= found_count + COUNT_W'(1);
        if (STOP_ON_FIRST != 0) stopped <= 1'b1;
      end
      rd_ptr    <= rd_next_c;
      occ       <= occ_next_c;
      valid_sal <= head_valid_c;
      nonce_out <= head_nonce_c;
      chan_out  <= head_chan_c;
    end
  end

  // Payload storage; validity is tracked by pend/occ
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (load_c[i]) slot[i] <= ch_nonce[i*NONCE_W +: NONCE_W];
    end
    if (push_c && !clear) begin
      mem_nonce[wr_ptr] <= slot[gnt_idx_c];
      mem_chan[wr_ptr]  <= gnt_idx_c;
    end
  end

endmodule

// File: tb/tb_nonce_result_collector.sv
// Bench for nonce_result_collector: directed scenarios plus random traffic
// against a queue-based reference model; a second instance covers stop-on-first.
module tb_nonce_result_collector;
  localparam int NW = 32;
  localparam int CH = 4;
  localparam int DEPTH = 4;
  localparam int COUNT_W = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear;
  logic [CH-1:0]   ch_valid;
  logic [CH*NW-1:0] ch_nonce;
  logic            ready_in;

  logic            valid_sal, finished, overflow;
  logic [NW-1:0]   nonce_out;
  logic [1:0]      chan_out;
  logic [COUNT_W-1:0] found_count;

  logic            s_valid, s_fin, s_ovf;
  logic [NW-1:0]   s_nonce;
  logic [1:0]      s_chan;
  logic [COUNT_W-1:0] s_found;

  int checks = 0;
  int errors = 0;

  nonce_result_collector #(.NONCE_W(NW), .CHANNELS(CH), .DEPTH(DEPTH),
                           .COUNT_W(COUNT_W), .STOP_ON_FIRST(0)) dut (
    .clk(clk), .reset(reset), .clear(clear), .ch_valid(ch_valid), .ch_nonce(ch_nonce),
    .valid_sal(valid_sal), .ready_in(ready_in), .nonce_out(nonce_out), .chan_out(chan_out),
    .finished(finished), .found_count(found_count), .overflow(overflow));

  nonce_result_collector #(.NONCE_W(NW), .CHANNELS(CH), .DEPTH(DEPTH),
                           .COUNT_W(COUNT_W), .STOP_ON_FIRST(1)) dut_s (
    .clk(clk), .reset(reset), .clear(clear), .ch_valid(ch_valid), .ch_nonce(ch_nonce),
    .valid_sal(s_valid), .ready_in(ready_in), .nonce_out(s_nonce), .chan_out(s_chan),
    .finished(s_fin), .found_count(s_found), .overflow(s_ovf));

  always #5 clk = ~clk;

  // Reference model state (STOP_ON_FIRST=0 instance)
  bit          m_pend [CH];
  logic [31:0] m_slot [CH];
  int          m_rr;
  logic [33:0] m_q [$];
  bit          m_fin;
  int          m_cnt;
  bit          m_ovf;

  function automatic void m_reset();
    for (int i = 0; i < CH; i++) m_pend[i] = 1'b0;
    m_rr = CH - 1;
    m_q.delete();
    m_fin = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endfunction

  function automatic void m_step();
    bit pop;
    int g;
    int c;
    logic [33:0] entry;
    if (!reset || clear) begin
      m_reset();
      return;
    end
    pop = (m_q.size() > 0) && ready_in;
    g = -1;
    if (m_q.size() < DEPTH)
      for (int k = 1; k <= CH; k++) begin
        c = (m_rr + k) % CH;
        if (g < 0 && m_pend[c]) g = c;
      end
    entry = '0;
    if (g >= 0) begin
      entry = {2'(g), m_slot[g]};
      m_pend[g] = 1'b0;
    end
    for (int i = 0; i < CH; i++)
      if (ch_valid[i]) begin
        if (!m_pend[i]) begin
          m_pend[i] = 1'b1;
          m_slot[i] = ch_nonce[i*NW +: NW];
        end else m_ovf = 1'b1;
      end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(entry);
      m_rr = g;
      m_fin = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [33:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 34'h0;
    chk("valid_sal", 64'(valid_sal), 64'(m_q.size() > 0));
    chk("nonce_out", 64'(nonce_out), 64'(h[31:0]));
    chk("chan_out", 64'(chan_out), 64'(h[33:32]));
    chk("finished", 64'(finished), 64'(m_fin));
    chk("found_count", 64'(found_count), 64'(m_cnt));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    #1;
    compare_all();
  endtask

  task automatic set_nonce(input int c, input logic [31:0] v);
    ch_nonce[c*NW +: NW] = v;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  logic [31:0] got [$];
  logic [31:0] s_got_n [$];
  logic [1:0]  s_got_c [$];

  initial begin
    reset = 1'b1; clear = 1'b0; ch_valid = '0; ch_nonce = '0; ready_in = 1'b0;
    #1 reset = 1'b0;
    m_reset();
    cycle(); cycle();
    chk("rst_valid", 64'(valid_sal), 64'd0);
    chk("rst_count", 64'(found_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_fin", 64'(finished), 64'd0);
    reset = 1'b1;
    cycle();

    // Single result with two-cycle latency
    ready_in = 1'b1;
    ch_valid = 4'b0100; set_nonce(2, 32'hDEADBEEF);
    cycle();
    ch_valid = '0;
    chk("single_lat1", 64'(valid_sal), 64'd0);
    cycle();
    chk("single_valid", 64'(valid_sal), 64'd1);
    chk("single_nonce", 64'(nonce_out), 64'hDEADBEEF);
    chk("single_chan", 64'(chan_out), 64'd2);
    chk("single_fin", 64'(finished), 64'd1);
    chk("single_cnt", 64'(found_count), 64'd1);
    cycle();
    chk("single_gone", 64'(valid_sal), 64'd0);

    // Contention: round-robin order twice
    do_clear();
    for (int r = 0; r < 2; r++) begin
      ch_valid = 4'hF;
      for (int i = 0; i < CH; i++) set_nonce(i, 32'h10 + 32'(i));
      cycle();
      ch_valid = '0;
      for (int i = 0; i < CH; i++) begin
        cycle();
        chk("rr_chan", 64'(chan_out), 64'(i));
        chk("rr_nonce", 64'(nonce_out), 64'h10 + 64'(i));
      end
    end
    cycle();
    chk("rr_ovf", 64'(overflow), 64'd0);

    // Backpressure: 4 buffered, 5th held in slot, 6th dropped
    do_clear();
    ready_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      ch_valid = 4'b0010; set_nonce(1, 32'h100 + 32'(k));
      cycle();
      ch_valid = '0;
      cycle();
    end
    chk("bp_ovf", 64'(overflow), 64'd1);
    chk("bp_cnt", 64'(found_count), 64'd4);
    chk("bp_head", 64'(nonce_out), 64'h101);
    ready_in = 1'b1;
    got.delete();
    repeat (12) begin
      if (valid_sal) got.push_back(nonce_out);
      cycle();
    end
    chk("bp_nout", 64'(got.size()), 64'd5);
    for (int k = 0; k < got.size(); k++) chk("bp_order", 64'(got[k]), 64'h101 + 64'(k));
    chk("bp_cnt5", 64'(found_count), 64'd5);

    // Slot refill on grant
    do_clear();
    ch_valid = 4'b0001; set_nonce(0, 32'hA0);
    cycle();
    set_nonce(0, 32'hA1);
    cycle();
    ch_valid = '0;
    cycle(); cycle(); cycle();
    chk("refill_ovf", 64'(overflow), 64'd0);
    chk("refill_cnt", 64'(found_count), 64'd2);

    // Stop-on-first instance
    do_clear();
    ch_valid = 4'b1010; set_nonce(1, 32'hAAAA0001); set_nonce(3, 32'hAAAA0003);
    cycle();
    ch_valid = '0;
    s_got_n.delete(); s_got_c.delete();
    repeat (4) begin
      if (s_valid) begin s_got_n.push_back(s_nonce); s_got_c.push_back(s_chan); end
      cycle();
    end
    ch_valid = 4'b0001; set_nonce(0, 32'hAAAA0000);
    cycle();
    ch_valid = '0;
    repeat (5) begin
      if (s_valid) begin s_got_n.push_back(s_nonce); s_got_c.push_back(s_chan); end
      cycle();
    end
    chk("sof_nout", 64'(s_got_n.size()), 64'd1);
    if (s_got_n.size() > 0) begin
      chk("sof_chan", 64'(s_got_c[0]), 64'd1);
      chk("sof_nonce", 64'(s_got_n[0]), 64'hAAAA0001);
    end
    chk("sof_cnt", 64'(s_found), 64'd1);
    chk("sof_ovf", 64'(s_ovf), 64'd0);
    chk("sof_fin", 64'(s_fin), 64'd1);
    do_clear();
    ch_valid = 4'b0001; set_nonce(0, 32'hBBBB0000);
    cycle();
    ch_valid = '0;
    cycle();
    chk("sof_after_clr_v", 64'(s_valid), 64'd1);
    chk("sof_after_clr_c", 64'(s_chan), 64'd0);
    chk("sof_after_clr_n", 64'(s_nonce), 64'hBBBB0000);

    // Random traffic against the model
    do_clear();
    for (int n = 0; n < 400; n++) begin
      ch_valid = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      for (int i = 0; i < CH; i++) set_nonce(i, $urandom());
      ready_in = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 59) == 0);
      cycle();
    end
    clear = 1'b0; ch_valid = '0;

    // Clear then asynchronous reset with entries buffered
    do_clear();
    ready_in = 1'b0;
    ch_valid = 4'b0111;
    cycle();
    ch_valid = '0;
    cycle(); cycle(); cycle();
    chk("mid_cnt3", 64'(found_count), 64'd3);
    do_clear();
    chk("clr_valid", 64'(valid_sal), 64'd0);
    chk("clr_cnt", 64'(found_count), 64'd0);
    chk("clr_fin", 64'(finished), 64'd0);
    ch_valid = 4'b0111;
    for (int i = 0; i < CH; i++) set_nonce(i, 32'h55 + 32'(i));
    cycle();
    ch_valid = '0;
    cycle(); cycle(); cycle();
    chk("pre_rst_valid", 64'(valid_sal), 64'd1);
    #3 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(valid_sal), 64'd0);
    chk("arst_nonce", 64'(nonce_out), 64'd0);
    chk("arst_chan", 64'(chan_out), 64'd0);
    chk("arst_cnt", 64'(found_count), 64'd0);
    chk("arst_fin", 64'(finished), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    m_reset();
    cycle();
    reset = 1'b1;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
